// File: rtl/audio_pkg.sv
// Shared constants, framer state type and width helper for the audio codec stream block.
package audio_pkg;
  localparam int FRAME_I2S = 0;
  localparam int FRAME_LJ  = 1;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } framer_state_e;

  function automatic int frame_w(input int data_w);
    return 2 * data_w;
  endfunction
endpackage

// File: rtl/audio_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
module audio_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             empty, full, do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign do_push = push & (~full | do_pop);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/audio_codec_stream.sv
// Stereo serial codec port (codec is bus master) <-> ready/valid {left,right} sample streams.
// Optional macro AUDIO_LOOPBACK_EN adds a loopback port that replays the last captured ADC frame on the DAC.
module audio_codec_stream
  import audio_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_MODE = FRAME_I2S
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
`ifdef AUDIO_LOOPBACK_EN
  input  logic                loopback,
`endif
  input  logic                aud_bclk,
  input  logic                aud_adclrck,
  input  logic                aud_adcdat,
  input  logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic [2*DATA_W-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  input  logic [2*DATA_W-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                rx_overflow,
  output logic                tx_underflow,
  input  logic                clear_flags
);
  localparam int                FW         = frame_w(DATA_W);
  localparam int                AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic              LEFT_LVL   = (FRAME_MODE == FRAME_LJ);
  localparam logic              SKIP_FIRST = (FRAME_MODE == FRAME_I2S);
  localparam logic [DATA_W-1:0] MSB_MASK   = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------- synchronisers and edge detect ----------------
  logic [3:0] sync1, sync2;
  logic       bclk_d, adclrck_d, daclrck_d;
  logic [2:0] sync_vld;
  logic       armed, bclk_rise, bclk_fall, adc_edge, dac_edge, adc_left, dac_left, adc_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      bclk_d    <= 1'b0;
      adclrck_d <= 1'b0;
      daclrck_d <= 1'b0;
      sync_vld  <= '0;
    end else begin
      sync1     <= {aud_bclk, aud_adclrck, aud_adcdat, aud_daclrck};
      sync2     <= sync1;
      bclk_d    <= sync2[3];
      adclrck_d <= sync2[2];
      daclrck_d <= sync2[0];
      sync_vld  <= {sync_vld[1:0], 1'b1};
    end
  end

  // edges are ignored until the chain holds real samples, so reset values never fake an LRCK edge
  assign armed     = sync_vld[2];
  assign bclk_rise = armed &  sync2[3] & ~bclk_d;
  assign bclk_fall = armed & ~sync2[3] &  bclk_d;
  assign adc_edge  = armed & (sync2[2] ^ adclrck_d);
  assign dac_edge  = armed & (sync2[0] ^ daclrck_d);
  assign adc_left  = (sync2[2] == LEFT_LVL);
  assign dac_left  = (sync2[0] == LEFT_LVL);
  assign adc_dat   = sync2[1];

  // ---------------- RX framer ----------------
  framer_state_e     rx_st;
  logic              rx_skip, rx_push;
  logic [DATA_W-1:0] rx_mask, rx_sh, rx_left;
  logic [FW-1:0]     rx_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st    <= WAIT_SYNC;
      rx_skip  <= 1'b0;
      rx_push  <= 1'b0;
      rx_mask  <= '0;
      rx_sh    <= '0;
      rx_left  <= '0;
      rx_frame <= '0;
    end else if (!enable) begin
      rx_st   <= WAIT_SYNC;
      rx_push <= 1'b0;
      rx_mask <= '0;
    end else begin
      rx_push <= 1'b0;
      if (adc_edge) begin
        rx_mask <= MSB_MASK;
        rx_skip <= SKIP_FIRST;
        rx_sh   <= '0;
        if (adc_left) begin
          if (rx_st == RIGHT) begin
            rx_push  <= 1'b1;
            rx_frame <= {rx_left, rx_sh};
          end
          rx_st <= LEFT;
        end else if (rx_st == LEFT) begin
          rx_left <= rx_sh;
          rx_st   <= RIGHT;
        end
      end else if (bclk_rise && rx_st != WAIT_SYNC) begin
        // one-hot mask walks MSB->LSB; once empty, extra bits fall away and missing ones stay 0
        if (rx_skip) rx_skip <= 1'b0;
        else begin
          if (adc_dat) rx_sh <= rx_sh | rx_mask;
          rx_mask <= rx_mask >> 1;
        end
      end
    end
  end

  // ---------------- FIFOs ----------------
  logic [FW-1:0] rx_rdata, tx_rdata;
  logic [AW:0]   rx_count, tx_count;
  logic          rx_pop, rx_fifo_push, tx_push, tx_pop;

  assign rx_valid     = (rx_count != '0);
  assign rx_data      = rx_valid ? rx_rdata : '0;
  assign rx_pop       = rx_valid & rx_ready;
  assign rx_fifo_push = rx_push & enable;
  assign tx_ready     = (tx_count != FULL_CNT) & enable & armed;
  assign tx_push      = tx_valid & tx_ready;

  audio_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .flush(~enable),
    .push(rx_fifo_push), .wdata(rx_frame),
    .pop(rx_pop), .rdata(rx_rdata), .count(rx_count)
  );

  audio_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .flush(~enable),
    .push(tx_push), .wdata(tx_data),
    .pop(tx_pop), .rdata(tx_rdata), .count(tx_count)
  );

  // ---------------- TX framer ----------------
  framer_state_e     tx_st;
  logic [1:0]        tx_pipe;   // [0] load slot, [1] first-bit slot after an LRCK edge
  logic              tx_skip, tx_load, use_lb, tx_udf_evt;
  logic [DATA_W-1:0] tx_mask, tx_chan;
  logic [FW-1:0]     tx_word;

`ifdef AUDIO_LOOPBACK_EN
  assign use_lb = loopback;
`else
  assign use_lb = 1'b0;
`endif

  assign tx_load    = enable & tx_pipe[0] & (tx_st == LEFT);
  assign tx_pop     = tx_load & ~use_lb & (tx_count != '0);
  assign tx_udf_evt = tx_load & ~use_lb & (tx_count == '0);
  assign tx_chan    = (tx_st == RIGHT) ? tx_word[DATA_W-1:0] : tx_word[FW-1:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st      <= WAIT_SYNC;
      tx_pipe    <= '0;
      tx_skip    <= 1'b0;
      tx_mask    <= '0;
      tx_word    <= '0;
      aud_dacdat <= 1'b0;
    end else if (!enable) begin
      tx_st      <= WAIT_SYNC;
      tx_pipe    <= '0;
      tx_mask    <= '0;
      aud_dacdat <= 1'b0;
    end else begin
      tx_pipe <= {tx_pipe[0], 1'b0};
      if (dac_edge && (dac_left || tx_st != WAIT_SYNC)) begin
        tx_st      <= dac_left ? LEFT : RIGHT;
        tx_mask    <= MSB_MASK;
        tx_skip    <= SKIP_FIRST;
        tx_pipe[0] <= 1'b1;
      end
      if (tx_load) tx_word <= use_lb ? rx_frame : ((tx_count != '0) ? tx_rdata : '0);
      // the BCLK fall that coincides with the LRCK edge is replayed two cycles later, once the word is loaded
      if (tx_pipe[1] || (bclk_fall && !dac_edge && tx_st != WAIT_SYNC)) begin
        if (tx_skip) begin
          tx_skip    <= 1'b0;
          aud_dacdat <= 1'b0;
        end else begin
          aud_dacdat <= |(tx_chan & tx_mask);
          tx_mask    <= tx_mask >> 1;
        end
      end
    end
  end

  // ---------------- sticky flags ----------------
  logic rx_ovf_evt;
  assign rx_ovf_evt = rx_fifo_push & (rx_count == FULL_CNT) & ~rx_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      rx_overflow  <= rx_ovf_evt | (rx_overflow & ~clear_flags);
      tx_underflow <= tx_udf_evt | (tx_underflow & ~clear_flags);
    end
  end
endmodule

// File: tb/tb_audio_codec_stream.sv
// Directed bench: one I2S and one left-justified instance driven by the same codec frames.
module tb_audio_codec_stream;
  localparam int DW = 24;
  localparam int FW = 48;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          reset_n, enable, bclk, lrck_i, lrck_j, dat_i, dat_j, dac_i, dac_j;
  logic [FW-1:0] rxd_i, rxd_j, tx_data;
  logic          rxv_i, rxv_j, rx_ready, tx_valid, txr_i, txr_j;
  logic          ovf_i, ovf_j, udf_i, udf_j, clear_flags;
`ifdef AUDIO_LOOPBACK_EN
  logic          loopback;
`endif
  logic [31:0]   dli, dri, dlj, drj;
  int            checks = 0;
  int            errors = 0;

  audio_codec_stream #(.DATA_W(DW), .FIFO_DEPTH(16), .FRAME_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
`ifdef AUDIO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .aud_bclk(bclk), .aud_adclrck(lrck_i), .aud_adcdat(dat_i), .aud_daclrck(lrck_i), .aud_dacdat(dac_i),
    .rx_data(rxd_i), .rx_valid(rxv_i), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_i),
    .rx_overflow(ovf_i), .tx_underflow(udf_i), .clear_flags(clear_flags)
  );

  audio_codec_stream #(.DATA_W(DW), .FIFO_DEPTH(16), .FRAME_MODE(1)) dut_lj (
    .clk(clk), .reset_n(reset_n), .enable(enable),
`ifdef AUDIO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .aud_bclk(bclk), .aud_adclrck(lrck_j), .aud_adcdat(dat_j), .aud_daclrck(lrck_j), .aud_dacdat(dac_j),
    .rx_data(rxd_j), .rx_valid(rxv_j), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_j),
    .rx_overflow(ovf_j), .tx_underflow(udf_j), .clear_flags(clear_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One stereo frame at 64 BCLK/frame, 16 clk per BCLK; DACDAT sampled just before each rise.
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int rst_at);
    logic [23:0] w;
    for (int ph = 0; ph < 2; ph++) begin
      w = (ph == 0) ? l : r;
      for (int b = 0; b < 32; b++) begin
        bclk = 1'b0;
        if (b == 0) begin
          lrck_i = (ph == 1);
          lrck_j = (ph == 0);
        end
        dat_i = (b >= 1 && b <= 24) ? w[24-b] : 1'b0;
        dat_j = (b < 24) ? w[23-b] : 1'b0;
        repeat (8) @(negedge clk);
        if (ph == 0 && b == rst_at) begin
          reset_n = 1'b0;
          @(negedge clk);
          reset_n = 1'b1;
        end
        if (ph == 0) begin
          dli[31-b] = dac_i;
          dlj[31-b] = dac_j;
        end else begin
          dri[31-b] = dac_i;
          drj[31-b] = dac_j;
        end
        bclk = 1'b1;
        repeat (8) @(negedge clk);
      end
    end
  endtask

  task automatic pop_chk(input string tag, input logic [47:0] exp);
    chk({tag, "_valid"}, 64'(rxv_i), 64'd1);
    chk({tag, "_i2s"}, 64'(rxd_i), 64'(exp));
    chk({tag, "_lj"}, 64'(rxd_j), 64'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  function automatic logic [47:0] pat(input int k);
    return {8'(k), 16'hA5A5, 16'h5A5A, 8'(k)};
  endfunction

  initial begin
    logic [47:0] f;
    reset_n = 1'b0; enable = 1'b1; bclk = 1'b1; lrck_i = 1'b1; lrck_j = 1'b0;
    dat_i = 1'b0; dat_j = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0; clear_flags = 1'b0;
`ifdef AUDIO_LOOPBACK_EN
    loopback = 1'b0;
`endif
    dli = '0; dri = '0; dlj = '0; drj = '0;
    repeat (3) @(negedge clk);
    chk("rst_dacdat", 64'(dac_i), 64'd0);
    chk("rst_rx_valid", 64'(rxv_i), 64'd0);
    chk("rst_rx_data", 64'(rxd_i), 64'd0);
    chk("rst_tx_ready", 64'(txr_i), 64'd0);
    chk("rst_ovf", 64'(ovf_i), 64'd0);
    chk("rst_udf", 64'(udf_i), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("tx_ready_up", 64'({txr_i, txr_j}), 64'b11);

    // DAC playback of one pushed frame
    tx_data = 48'h800001_7FFFFF; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    send_frame(24'hABCDEF, 24'h123456, -1);
    chk("dac_l_i2s", 64'(dli), 64'h40000080);
    chk("dac_r_i2s", 64'(dri), 64'h3FFFFF80);
    chk("dac_l_lj", 64'(dlj), 64'h80000100);
    chk("dac_r_lj", 64'(drj), 64'h7FFFFF00);
    chk("rx_not_yet", 64'(rxv_i), 64'd0);
    chk("udf_clear", 64'(udf_i), 64'd0);

    // first frame lands on the next RIGHT->LEFT edge; this frame's DAC finds TX empty
    send_frame(24'h111111, 24'h222222, -1);
    chk("rx_i2s", 64'(rxd_i), 64'hABCDEF123456);
    chk("rx_lj", 64'(rxd_j), 64'hABCDEF123456);
    chk("rx_valid", 64'({rxv_i, rxv_j}), 64'b11);
    chk("udf_dac_zero", 64'({dli, dri}), 64'd0);
    chk("udf_set", 64'({udf_i, udf_j}), 64'b11);

    // enable low flushes FIFOs, keeps flags
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_flush", 64'(rxv_i), 64'd0);
    chk("dis_tx_ready", 64'(txr_i), 64'd0);
    chk("dis_udf_kept", 64'(udf_i), 64'd1);
    enable = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    @(negedge clk);
    chk("udf_cleared", 64'(udf_i), 64'd0);

    // overflow: frame 3 re-syncs, frames 3..18 fill the FIFO, frame 19 is dropped
    for (int k = 3; k < 20; k++) begin
      f = pat(k);
      send_frame(f[47:24], f[23:0], -1);
    end
    chk("ovf_not_yet", 64'(ovf_i), 64'd0);
    f = pat(20);
    send_frame(f[47:24], f[23:0], -1);
    chk("ovf_set", 64'({ovf_i, ovf_j}), 64'b11);
    for (int k = 3; k < 19; k++) pop_chk($sformatf("pop%0d", k), pat(k));
    chk("ovf_drained", 64'(rxv_i), 64'd0);

    // reset in the middle of a left channel: partial frame never appears
    send_frame(24'hAAAAAA, 24'hBBBBBB, 10);
    chk("rst_mid_ovf", 64'(ovf_i), 64'd0);
    send_frame(24'h13579B, 24'h2468AC, -1);
    send_frame(24'h000000, 24'h000000, -1);
    pop_chk("after_rst", 48'h13579B_2468AC);
    chk("after_rst_only", 64'(rxv_i), 64'd0);

`ifdef AUDIO_LOOPBACK_EN
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    loopback = 1'b1;
    send_frame(24'hC0FFEE, 24'h00BEEF, -1);
    send_frame(24'h000000, 24'h000000, -1);
    chk("lb_l_i2s", 64'(dli), 64'h607FF700);
    chk("lb_r_i2s", 64'(dri), 64'h005F7780);
    chk("lb_no_udf", 64'(udf_i), 64'd0);
    loopback = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
